// File: rtl/spike_output_serializer.sv
// spike_output_serializer: captures per-column spike strobes from nn, tags
// each with column and capture timestamp, and streams them out one by one.
// Ports: clk, reset_n (async, active-low); spike_valid/spike_on_off
// [NUM_COLS] inputs; out_valid/out_ready stream with out_col, out_on_off,
// out_timestamp; fifo_level occupancy; drop_count saturating loss counter.
// Optional: SPIKE_SERIALIZER_TIMESTAMP_EN enables the timestamp path;
// when undefined out_timestamp is tied to 0.
module spike_output_serializer #(
  parameter int NUM_COLS   = 48,
  parameter int TS_WIDTH   = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_COLS-1:0]           spike_valid,
  input  logic [NUM_COLS-1:0]           spike_on_off,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(NUM_COLS)-1:0]   out_col,
  output logic                          out_on_off,
  output logic [TS_WIDTH-1:0]           out_timestamp,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(NUM_COLS + 1);

  logic [NUM_COLS-1:0] pending;
  logic [NUM_COLS-1:0] pend_on_off;
  logic [NUM_COLS-1:0] grant_mask;
  logic [NUM_COLS-1:0] capture;
  logic [NUM_COLS-1:0] dropped;
  logic [CW-1:0]       ptr;
  logic [CW-1:0]       grant_col;
  logic                grant;
  logic [CW:0]         arb_sum;
  logic [CW-1:0]       arb_idx;
  logic [DW-1:0]       drops;
  logic [16:0]         drop_sum;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         level;
  logic                full;
  logic                pop;
  logic                wr_ok;
  logic [CW-1:0]       mem_col [FIFO_DEPTH];
  logic                mem_pol [FIFO_DEPTH];

  assign out_valid  = level != '0;
  assign fifo_level = level;
  assign full       = level == (AW+1)'(FIFO_DEPTH);
  assign pop        = out_valid & out_ready;
  assign wr_ok      = ~full | pop;

  // Round-robin: first pending column at or after ptr, wrapping.
  always_comb begin
    grant     = 1'b0;
    grant_col = '0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      arb_sum = {1'b0, ptr} + (CW+1)'(i);
      if (arb_sum >= (CW+1)'(NUM_COLS))
        arb_sum = arb_sum - (CW+1)'(NUM_COLS);
      arb_idx = arb_sum[CW-1:0];
      if (!grant && wr_ok && pending[arb_idx]) begin
        grant     = 1'b1;
        grant_col = arb_idx;
      end
    end
  end

  assign grant_mask = grant
    ? {{(NUM_COLS-1){1'b0}}, 1'b1} << grant_col
    : '0;

  // A granted column frees its slot this cycle, so a new spike lands.
  assign capture = spike_valid & (~pending | grant_mask);
  assign dropped = spike_valid & pending & ~grant_mask;

  always_comb begin
    drops = '0;
    for (int c = 0; c < NUM_COLS; c++)
      drops = drops + DW'(dropped[c]);
  end

  assign drop_sum = {1'b0, drop_count} + 17'(drops);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= '0;
      pend_on_off <= '0;
      ptr         <= '0;
      drop_count  <= '0;
    end else begin
      for (int c = 0; c < NUM_COLS; c++) begin
        if (capture[c]) begin
          pending[c]     <= 1'b1;
          pend_on_off[c] <= spike_on_off[c];
        end else if (grant_mask[c]) begin
          pending[c] <= 1'b0;
        end
      end
      if (grant)
        ptr <= (grant_col == CW'(NUM_COLS - 1))
          ? '0 : grant_col + CW'(1);
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({grant, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array carries no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (grant) begin
      mem_col[wr_ptr] <= grant_col;
      mem_pol[wr_ptr] <= pend_on_off[grant_col];
    end
  end

  assign out_col    = out_valid ? mem_col[rd_ptr] : '0;
  assign out_on_off = out_valid ? mem_pol[rd_ptr] : 1'b0;

`ifdef SPIKE_SERIALIZER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] pend_ts [NUM_COLS];
  logic [TS_WIDTH-1:0] mem_ts  [FIFO_DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt <= '0;
      for (int c = 0; c < NUM_COLS; c++)
        pend_ts[c] <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
      for (int c = 0; c < NUM_COLS; c++)
        if (capture[c]) pend_ts[c] <= ts_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) mem_ts[wr_ptr] <= pend_ts[grant_col];
  end

  assign out_timestamp = out_valid ? mem_ts[rd_ptr] : '0;
`else
  assign out_timestamp = '0;
`endif

endmodule

// File: doc/spike_output_serializer.md
# spike_output_serializer

- Collects spike events from the `NUM_COLS` neuron column outputs of `nn` (per column: `valid`, `on_off`) and returns them one at a time.
- Each event is tagged with its column index and a capture timestamp, buffered in a FIFO, and presented on a single valid/ready stream.
- It sits at the output side of `nn`, in parallel with `external_spike_router`. It lets the host or a bench read out network activity without sampling every column every cycle.

## Interface
- `NUM_COLS`, 48, number of neuron columns observed
- `TS_WIDTH`, 16, timestamp counter width
- `FIFO_DEPTH`, 16, event FIFO entries (power of two, ≥2)
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `spike_valid`  in  NUM_COLS  per-column spike strobe, one-cycle pulse
- `spike_on_off`  in  NUM_COLS  per-column spike polarity, qualified by `spike_valid`
- `out_valid`  out  1  event available
- `out_ready`  in  1  consumer accepts event
- `out_col`  out  $clog2(NUM_COLS)  source column of event
- `out_on_off`  out  1  event polarity
- `out_timestamp`  out  TS_WIDTH  capture timestamp
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- `drop_count`  out  16  saturating count of lost spikes

## Operation
- **Timestamp counter**
  - Free-running, +1 every cycle.
  - Wraps from 2^TS_WIDTH−1 to 0.
- **Capture stage**, per column:
  - Registers `pending`, `pend_on_off` and `pend_ts`.
  - On a `spike_valid[c]` sample with `pending[c]`=0: set `pending[c]`, store polarity and the current counter value.
  - On a `spike_valid[c]` sample with `pending[c]`=1 and column c not granted this cycle: discard the new spike, keep the stored spike, and increment `drop_count` by 1.
  - On a `spike_valid[c]` sample in the same cycle that column c is granted: the new spike is stored as the new pending entry. This is not a drop.
  - When several columns drop in the same cycle, `drop_count` increases by the number of drops. It saturates at 0xFFFF.
- **Arbiter**
  - Round-robin over the `pending` bits; at most one grant per cycle.
  - A grant happens only when a FIFO write is allowed: not full, or full with a pop in the same cycle.
  - Priority pointer resets to column 0. After a grant of column k, the pointer moves to k+1, wrapping from NUM_COLS−1 to 0.
  - A granted column writes {col, on_off, ts} into the FIFO, and its `pending` bit clears unless it is re-set by a simultaneous spike.
- **FIFO and output stream**
  - Show-ahead: the head entry drives `out_col`, `out_on_off` and `out_timestamp`.
  - `out_valid` = FIFO not empty.
  - Pop on `out_valid && out_ready`.
  - Outputs are stable while `out_valid`=1 and `out_ready`=0.
- **Backpressure**
  - A full FIFO stalls the arbiter only; events wait in `pending`.
  - Data loss happens only through the capture-stage drop rule.

## Timing
- Reset values:
  - `out_valid`=0, `out_col`=0, `out_on_off`=0, `out_timestamp`=0.
  - `fifo_level`=0, `drop_count`=0.
  - Counter=0, all `pending`=0, pointer=0.
- Assertion of `reset_n` mid-operation immediately clears all state, including FIFO contents and pending spikes. Spikes arriving during reset are ignored.
- Latency: a spike sampled at edge t (counter value T) is pending after t and written to the FIFO at edge t+1 if granted. `out_valid` rises after edge t+1, so minimum latency is 2 edges. The timestamp reported is T.
- Throughput: 1 event per cycle in and out.
- `fifo_level` updates on the same edge as push/pop. Simultaneous push and pop leaves the level unchanged.
- Empty FIFO: there is no bypass. A grant and a pop cannot occur for the same entry in one cycle.

## Configuration
- `SPIKE_SERIALIZER_TIMESTAMP_EN` defined:
  - Counter, `pend_ts` registers and FIFO timestamp field are implemented as described.
- Not defined:
  - Counter, `pend_ts` registers and the timestamp field are removed.
  - `out_timestamp` is tied to 0.
  - All other behaviour and latency are unchanged.

## Test plan
- **Single spike:** after reset, pulse col 5 with on_off=1 at counter value 10, `out_ready`=1 → one event {col=5, on_off=1, ts=10}, `out_valid` for exactly 1 cycle, first visible 2 edges after the sample.
- **Simultaneous spikes:** pulse cols 0, 3 and 47 in the same cycle, `out_ready`=1 → events emerge in order 0, 3, 47 on consecutive cycles, all with the same ts. A following all-column burst starts at col 0 again, with the pointer at 48→0.
- **Drop:** hold `out_ready`=0 and pulse col 2 in 20 consecutive cycles → FIFO holds 16 events. The 17th spike is stored in `pending`, the remaining 3 spikes are dropped, `drop_count`=3 and `fifo_level`=16. Releasing `out_ready` yields 17 events total.
- **Timestamp wrap:** with TS_WIDTH=4, spikes at counter 15 and then 0 → reported ts 15, then 0.
- **Reset mid-operation:** with FIFO level 5 and 2 columns pending, pulse `reset_n` low for 1 ns → `out_valid`=0, `fifo_level`=0, `drop_count`=0 immediately, and no stale events appear afterwards.
- **Macro off:** rerun the single-spike test without `SPIKE_SERIALIZER_TIMESTAMP_EN` → identical col, polarity and latency, with `out_timestamp`=0.
